// File: rtl/dac_pkg.sv
// Shared definitions for the DAC channel scheduler: channel count, bus widths,
// FSM state encoding and the round-robin channel picker.
package dac_pkg;

  localparam int N_CH   = 8;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  // First set bit of pend at or after ptr, wrapping N_CH-1 -> 0.
  // Scanning from the farthest offset down lets the nearest hit win.
  function automatic logic [ADDR_W-1:0] rr_pick(input logic [N_CH-1:0]   pend,
                                                input logic [ADDR_W-1:0] ptr);
    logic [ADDR_W-1:0] idx;
    rr_pick = ptr;
    for (int i = N_CH - 1; i >= 0; i--) begin
      idx = ptr + ADDR_W'(i);
      if (pend[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/dac_ch_scheduler_if.sv
// Host/serializer bus of the DAC channel scheduler.
//   slave  : the scheduler (inputs: setpoint writes, control, DAC_DONE;
//            outputs: DAC request, status)
//   master : the host / serializer side driving the scheduler
interface dac_ch_scheduler_if;
  import dac_pkg::*;

  logic              WR_EN;
  logic [ADDR_W-1:0] WR_CH;
  logic [DATA_W-1:0] WR_DATA;
  logic              FORCE_ALL;
  logic              ENABLE;
  logic              DAC_TRIG;
  logic [ADDR_W-1:0] DAC_ADDR;
  logic [DATA_W-1:0] DAC_DATA;
  logic              DAC_DONE;
  logic              BUSY;
  logic [N_CH-1:0]   PENDING;
  logic              ERR_TIMEOUT;
  logic              ERR_CLR;

  modport slave (
    input  WR_EN, WR_CH, WR_DATA, FORCE_ALL, ENABLE, DAC_DONE, ERR_CLR,
    output DAC_TRIG, DAC_ADDR, DAC_DATA, BUSY, PENDING, ERR_TIMEOUT
  );

  modport master (
    output WR_EN, WR_CH, WR_DATA, FORCE_ALL, ENABLE, DAC_DONE, ERR_CLR,
    input  DAC_TRIG, DAC_ADDR, DAC_DATA, BUSY, PENDING, ERR_TIMEOUT
  );

endinterface

// File: rtl/sync_bit.sv
// Single-bit multi-flop synchronizer for a level crossing into clk_i.
//   clk_i   destination clock
//   rst_n_i asynchronous active-low reset, clears every stage
//   d_i     asynchronous input level
//   q_o     synchronized level, STAGES cycles later
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/dac_ch_scheduler.sv
// DAC channel scheduler: eight shadow setpoints with dirty flags, sent one at a
// time to a downstream serializer through a TRIG/DONE four-phase handshake,
// round-robin across dirty channels, with a handshake timeout.
//   OPB_CLK, OPB_RST_N  clock, asynchronous active-low reset
//   bus (slave)         WR_* setpoint write, FORCE_ALL, ENABLE, ERR_CLR in;
//                       DAC_TRIG/ADDR/DATA out, DAC_DONE in (async);
//                       BUSY, PENDING, ERR_TIMEOUT status out
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | no transfer; picks next dirty channel when enabled
// ST_ISSUE   | DAC_TRIG high, ADDR/DATA held, waiting for done_s=1
// ST_RELEASE | DAC_TRIG low, waiting for done_s=0
module dac_ch_scheduler
  import dac_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int SYNC_STAGES    = 2
) (
  input  logic               OPB_CLK,
  input  logic               OPB_RST_N,
  dac_ch_scheduler_if.slave  bus
);

  localparam int                WAIT_W   = $clog2(TIMEOUT_CYCLES + 1);
  // Down-counter reloaded on every state entry; terminal count is zero.
  localparam logic [WAIT_W-1:0] WAIT_LD  = WAIT_W'(TIMEOUT_CYCLES - 1);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shadow_q [N_CH];
  logic [N_CH-1:0]     pending_q, pending_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                trig_q, trig_d;
  logic [ADDR_W-1:0]   rr_q, rr_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                err_q, err_d;

  logic                done_s;
  logic                timeout;
  logic [ADDR_W-1:0]   pick;
  logic [N_CH-1:0]     clr_mask, set_mask, wr_mask;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_done (
    .clk_i   (OPB_CLK),
    .rst_n_i (OPB_RST_N),
    .d_i     (bus.DAC_DONE),
    .q_o     (done_s)
  );

  always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
    if (!OPB_RST_N) begin
      for (int i = 0; i < N_CH; i++) shadow_q[i] <= '0;
    end else if (bus.WR_EN) begin
      shadow_q[bus.WR_CH] <= bus.WR_DATA;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    trig_d   = trig_q;
    rr_d     = rr_q;
    wait_d   = wait_q;
    timeout  = 1'b0;
    clr_mask = '0;
    set_mask = '0;
    wr_mask  = '0;
    pick     = rr_pick(pending_q, rr_q);

    case (state_q)
      ST_IDLE: begin
        wait_d = WAIT_LD;
        if (bus.ENABLE && (pending_q != '0) && !done_s) begin
          addr_d         = pick;
          data_d         = shadow_q[pick];
          clr_mask[pick] = 1'b1;
          trig_d         = 1'b1;
          state_d        = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (done_s) begin
          trig_d  = 1'b0;
          rr_d    = addr_q + 1'b1;
          wait_d  = WAIT_LD;
          state_d = ST_RELEASE;
        end else if (wait_q == '0) begin
          timeout          = 1'b1;
          set_mask[addr_q] = 1'b1;
          trig_d           = 1'b0;
          wait_d           = WAIT_LD;
          state_d          = ST_RELEASE;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      ST_RELEASE: begin
        if (!done_s) begin
          wait_d  = WAIT_LD;
          state_d = ST_IDLE;
        end else if (wait_q == '0) begin
          timeout          = 1'b1;
          set_mask[addr_q] = 1'b1;
          wait_d           = WAIT_LD;
          state_d          = ST_IDLE;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      default: begin
        trig_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    wr_mask[bus.WR_CH] = bus.WR_EN;
    // Sets are OR-ed in after the capture clear so a same-edge set survives.
    pending_d = (pending_q & ~clr_mask) | set_mask | wr_mask | {N_CH{bus.FORCE_ALL}};
    err_d     = timeout | (err_q & ~bus.ERR_CLR);
  end

  always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
    if (!OPB_RST_N) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      trig_q    <= 1'b0;
      rr_q      <= '0;
      wait_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      trig_q    <= trig_d;
      rr_q      <= rr_d;
      wait_q    <= wait_d;
      err_q     <= err_d;
    end
  end

  assign bus.DAC_TRIG    = trig_q;
  assign bus.DAC_ADDR    = addr_q;
  assign bus.DAC_DATA    = data_q;
  assign bus.BUSY        = (state_q != ST_IDLE);
  assign bus.PENDING     = pending_q;
  assign bus.ERR_TIMEOUT = err_q;

endmodule

// File: tb/tb_dac_ch_scheduler.sv
// Bench for dac_ch_scheduler: a DONE responder models the serializer, a monitor
// records every DAC_TRIG rising edge, and expected {addr,data} transfers are
// queued when writes are driven and compared in order as transfers appear.
// A second instance with a short timeout covers the handshake-timeout path.
module tb_dac_ch_scheduler;
  import dac_pkg::*;

  logic OPB_CLK   = 1'b0;
  logic OPB_RST_N = 1'b0;
  always #5 OPB_CLK = ~OPB_CLK;

  dac_ch_scheduler_if bus();
  dac_ch_scheduler_if bus_t();

  dac_ch_scheduler #(.TIMEOUT_CYCLES(4096), .SYNC_STAGES(2)) dut (
    .OPB_CLK   (OPB_CLK),
    .OPB_RST_N (OPB_RST_N),
    .bus       (bus)
  );

  dac_ch_scheduler #(.TIMEOUT_CYCLES(16), .SYNC_STAGES(2)) dut_t (
    .OPB_CLK   (OPB_CLK),
    .OPB_RST_N (OPB_RST_N),
    .bus       (bus_t)
  );

  int   checks = 0;
  int   errors = 0;
  int   resp_delay = 20;
  bit   resp_en = 1'b1;
  logic [10:0] exp_q[$];
  logic [10:0] obs_q[$];

  // Serializer model: DONE rises resp_delay cycles after TRIG, falls after TRIG drops.
  initial begin
    bus.DAC_DONE = 1'b0;
    forever begin
      @(posedge OPB_CLK); #1;
      if (resp_en && bus.DAC_TRIG) begin
        repeat (resp_delay) @(posedge OPB_CLK);
        #2 bus.DAC_DONE = 1'b1;
        while (bus.DAC_TRIG) begin
          @(posedge OPB_CLK); #1;
        end
        #1 bus.DAC_DONE = 1'b0;
      end
    end
  end

  // Transfer monitor.
  initial begin
    logic trig_prev;
    trig_prev = 1'b0;
    forever begin
      @(posedge OPB_CLK); #1;
      if (bus.DAC_TRIG && !trig_prev) obs_q.push_back({bus.DAC_ADDR, bus.DAC_DATA});
      trig_prev = bus.DAC_TRIG;
    end
  end

  task automatic wr(input logic [2:0] ch, input logic [7:0] d);
    @(negedge OPB_CLK);
    bus.WR_EN = 1'b1; bus.WR_CH = ch; bus.WR_DATA = d;
    @(posedge OPB_CLK); #1;
    bus.WR_EN = 1'b0;
  endtask

  task automatic wait_trig(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge OPB_CLK); #1;
      if (bus.DAC_TRIG) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_transfers(input int n);
    logic [10:0] o, e;
    for (int t = 0; t < n; t++) begin
      for (int c = 0; c < 400 && obs_q.size() == 0; c++) begin
        @(posedge OPB_CLK); #1;
      end
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL transfer_timeout: no transfer seen, expected %0d more", n - t);
        return;
      end
      o = obs_q.pop_front();
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 11'h7ff;
      if (o !== e) begin
        errors++;
        $display("FAIL transfer_order: got ch%0d data %02h, expected ch%0d data %02h",
                 o[10:8], o[7:0], e[10:8], e[7:0]);
      end
    end
    for (int c = 0; c < 100 && bus.BUSY; c++) begin
      @(posedge OPB_CLK); #1;
    end
    checks++;
    if (bus.BUSY !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_transfers: BUSY=%b expected 0", bus.BUSY);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.DAC_TRIG, bus.DAC_ADDR, bus.DAC_DATA, bus.BUSY, bus.PENDING, bus.ERR_TIMEOUT} !== '0) begin
      errors++;
      $display("FAIL reset_state: trig=%b addr=%0d data=%02h busy=%b pend=%02h err=%b, expected all 0",
               bus.DAC_TRIG, bus.DAC_ADDR, bus.DAC_DATA, bus.BUSY, bus.PENDING, bus.ERR_TIMEOUT);
    end
  endtask

  task automatic test_single();
    wr(3'd3, 8'h5A);
    exp_q.push_back({3'd3, 8'h5A});
    checks++;
    if (bus.PENDING !== 8'h08 || bus.DAC_TRIG !== 1'b0) begin
      errors++;
      $display("FAIL write_edge: pend=%02h trig=%b, expected 08 / 0", bus.PENDING, bus.DAC_TRIG);
    end
    @(posedge OPB_CLK); #1;
    checks++;
    if ({bus.DAC_TRIG, bus.DAC_ADDR, bus.DAC_DATA, bus.PENDING} !== {1'b1, 3'd3, 8'h5A, 8'h00}) begin
      errors++;
      $display("FAIL write_latency: trig=%b addr=%0d data=%02h pend=%02h, expected 1/3/5a/00",
               bus.DAC_TRIG, bus.DAC_ADDR, bus.DAC_DATA, bus.PENDING);
    end
    checks++;
    if (bus.BUSY !== 1'b1) begin
      errors++;
      $display("FAIL busy_in_issue: BUSY=%b expected 1", bus.BUSY);
    end
    check_transfers(1);
    checks++;
    if (bus.DAC_TRIG !== 1'b0 || bus.PENDING !== 8'h00) begin
      errors++;
      $display("FAIL single_done: trig=%b pend=%02h, expected 0 / 00", bus.DAC_TRIG, bus.PENDING);
    end
  endtask

  task automatic test_round_robin();
    wr(3'd1, 8'h10); exp_q.push_back({3'd1, 8'h10});
    wr(3'd5, 8'h50); exp_q.push_back({3'd5, 8'h50});
    wr(3'd6, 8'h60); exp_q.push_back({3'd6, 8'h60});
    check_transfers(3);
    bus.ENABLE = 1'b0;
    wr(3'd0, 8'h0A);
    wr(3'd2, 8'h2A);
    @(posedge OPB_CLK); #1;
    checks++;
    if (bus.PENDING !== 8'h05 || bus.BUSY !== 1'b0) begin
      errors++;
      $display("FAIL enable_blocks: pend=%02h busy=%b, expected 05 / 0", bus.PENDING, bus.BUSY);
    end
    exp_q.push_back({3'd0, 8'h0A});
    exp_q.push_back({3'd2, 8'h2A});
    bus.ENABLE = 1'b1;
    check_transfers(2);
  endtask

  task automatic test_inflight_write();
    bit ok;
    wr(3'd2, 8'h22); exp_q.push_back({3'd2, 8'h22});
    wait_trig(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL inflight_trig: DAC_TRIG=0 expected 1");
    end
    wr(3'd2, 8'h11); exp_q.push_back({3'd2, 8'h11});
    checks++;
    if ({bus.DAC_TRIG, bus.DAC_ADDR, bus.DAC_DATA} !== {1'b1, 3'd2, 8'h22} || bus.PENDING[2] !== 1'b1) begin
      errors++;
      $display("FAIL inflight_hold: trig=%b addr=%0d data=%02h pend=%02h, expected 1/2/22/pend[2]=1",
               bus.DAC_TRIG, bus.DAC_ADDR, bus.DAC_DATA, bus.PENDING);
    end
    check_transfers(2);
  endtask

  task automatic test_reset_mid();
    bit ok;
    wr(3'd6, 8'h66); exp_q.push_back({3'd6, 8'h66});
    wait_trig(ok);
    wr(3'd7, 8'h77);
    repeat (3) @(posedge OPB_CLK);
    #2 OPB_RST_N = 1'b0;
    #1;
    checks++;
    if ({bus.DAC_TRIG, bus.BUSY, bus.PENDING} !== '0 || !ok) begin
      errors++;
      $display("FAIL reset_mid: trig=%b busy=%b pend=%02h seen_trig=%b, expected 0/0/00/1",
               bus.DAC_TRIG, bus.BUSY, bus.PENDING, ok);
    end
    repeat (3) @(negedge OPB_CLK);
    OPB_RST_N = 1'b1;
    check_transfers(1);
    repeat (60) @(posedge OPB_CLK);
    #1;
    checks++;
    if (obs_q.size() != 0 || bus.PENDING !== 8'h00 || bus.DAC_TRIG !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard: extra transfers=%0d pend=%02h trig=%b, expected 0/00/0",
               obs_q.size(), bus.PENDING, bus.DAC_TRIG);
    end
  endtask

  task automatic test_force_all();
    bus.ENABLE = 1'b0;
    for (int i = 0; i < 8; i += 2) wr(3'(i), 8'h80 + 8'(i));
    checks++;
    if (bus.PENDING !== 8'h55) begin
      errors++;
      $display("FAIL force_pre: pend=%02h expected 55", bus.PENDING);
    end
    @(negedge OPB_CLK); bus.FORCE_ALL = 1'b1;
    @(negedge OPB_CLK); bus.FORCE_ALL = 1'b0;
    repeat (3) @(posedge OPB_CLK);
    #1;
    checks++;
    if (bus.PENDING !== 8'hFF || bus.DAC_TRIG !== 1'b0 || bus.BUSY !== 1'b0) begin
      errors++;
      $display("FAIL force_all: pend=%02h trig=%b busy=%b, expected ff/0/0",
               bus.PENDING, bus.DAC_TRIG, bus.BUSY);
    end
    for (int i = 0; i < 8; i++)
      exp_q.push_back({3'(i), (i % 2 == 0) ? 8'h80 + 8'(i) : 8'h00});
    bus.ENABLE = 1'b1;
    check_transfers(8);
  endtask

  task automatic test_timeout();
    bus_t.ENABLE = 1'b1;
    @(negedge OPB_CLK);
    bus_t.WR_EN = 1'b1; bus_t.WR_CH = 3'd4; bus_t.WR_DATA = 8'h33;
    @(posedge OPB_CLK); #1;
    bus_t.WR_EN = 1'b0;
    @(posedge OPB_CLK); #1;
    bus_t.ENABLE = 1'b0;
    checks++;
    if ({bus_t.DAC_TRIG, bus_t.DAC_ADDR, bus_t.DAC_DATA} !== {1'b1, 3'd4, 8'h33}) begin
      errors++;
      $display("FAIL tmo_issue: trig=%b addr=%0d data=%02h, expected 1/4/33",
               bus_t.DAC_TRIG, bus_t.DAC_ADDR, bus_t.DAC_DATA);
    end
    repeat (15) @(posedge OPB_CLK);
    #1;
    checks++;
    if (bus_t.ERR_TIMEOUT !== 1'b0 || bus_t.DAC_TRIG !== 1'b1) begin
      errors++;
      $display("FAIL tmo_early: err=%b trig=%b after 15 cycles, expected 0/1",
               bus_t.ERR_TIMEOUT, bus_t.DAC_TRIG);
    end
    @(posedge OPB_CLK); #1;
    checks++;
    if ({bus_t.ERR_TIMEOUT, bus_t.DAC_TRIG, bus_t.BUSY, bus_t.PENDING} !== {1'b1, 1'b0, 1'b1, 8'h10}) begin
      errors++;
      $display("FAIL tmo_fire: err=%b trig=%b busy=%b pend=%02h, expected 1/0/1/10",
               bus_t.ERR_TIMEOUT, bus_t.DAC_TRIG, bus_t.BUSY, bus_t.PENDING);
    end
    @(posedge OPB_CLK); #1;
    checks++;
    if (bus_t.BUSY !== 1'b0 || bus_t.ERR_TIMEOUT !== 1'b1) begin
      errors++;
      $display("FAIL tmo_sticky: busy=%b err=%b, expected 0/1", bus_t.BUSY, bus_t.ERR_TIMEOUT);
    end
    @(negedge OPB_CLK); bus_t.ERR_CLR = 1'b1;
    @(posedge OPB_CLK); #1;
    bus_t.ERR_CLR = 1'b0;
    checks++;
    if (bus_t.ERR_TIMEOUT !== 1'b0 || bus_t.PENDING !== 8'h10) begin
      errors++;
      $display("FAIL err_clr: err=%b pend=%02h, expected 0/10", bus_t.ERR_TIMEOUT, bus_t.PENDING);
    end
  endtask

  initial begin
    bus.WR_EN = 1'b0; bus.WR_CH = '0; bus.WR_DATA = '0;
    bus.FORCE_ALL = 1'b0; bus.ENABLE = 1'b1; bus.ERR_CLR = 1'b0;
    bus_t.WR_EN = 1'b0; bus_t.WR_CH = '0; bus_t.WR_DATA = '0;
    bus_t.FORCE_ALL = 1'b0; bus_t.ENABLE = 1'b0; bus_t.ERR_CLR = 1'b0;
    bus_t.DAC_DONE = 1'b0;
    repeat (3) @(negedge OPB_CLK);
    OPB_RST_N = 1'b1;
    @(posedge OPB_CLK); #1;
    test_reset();
    test_single();
    test_round_robin();
    test_inflight_write();
    test_reset_mid();
    test_force_all();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_ch_scheduler.md
DAC_CH_SCHEDULER -- requirements
Module: dac_ch_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 4096, meaning max OPB_CLK cycles waiting on any DAC_DONE edge.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning flops in the DAC_DONE synchronizer.
REQ-003 SHALL have ports:
- OPB_CLK  in  1  sole clock.
- OPB_RST_N  in  1  reset; asynchronous, active-low.
- WR_EN  in  1  setpoint write strobe.
- WR_CH  in  3  channel index 0-7.
- WR_DATA  in  8  setpoint code.
- FORCE_ALL  in  1  one-cycle pulse; marks all 8 channels dirty.
- ENABLE  in  1  permits new transfers.
- DAC_TRIG  out  1  start request to downstream serializer.
- DAC_ADDR  out  3  channel being sent.
- DAC_DATA  out  8  code being sent.
- DAC_DONE  in  1  serializer completion; asynchronous to OPB_CLK.
- BUSY  out  1  FSM not IDLE.
- PENDING  out  8  dirty flag per channel.
- ERR_TIMEOUT  out  1  sticky handshake-timeout flag.
- ERR_CLR  in  1  clears ERR_TIMEOUT.

Function
REQ-004 SHALL hold eight 8-bit shadow registers; WR_EN writes WR_DATA into shadow[WR_CH] and sets PENDING[WR_CH] on the same edge.
REQ-005 SHALL pass DAC_DONE through a SYNC_STAGES-flop synchronizer; the FSM SHALL use only the synchronized value done_s.
REQ-006 SHALL implement FSM states IDLE, ISSUE, RELEASE.
REQ-007 IDLE: when ENABLE=1, PENDING!=0 and done_s=0, SHALL select the first set PENDING bit at or after rr_ptr (wrapping 7->0), load DAC_ADDR/DAC_DATA from shadow, clear that PENDING bit, set DAC_TRIG=1, go ISSUE.
REQ-008 Write latency: WR_EN sampled at edge k on an idle block SHALL give DAC_TRIG=1 after edge k+1.
REQ-009 ISSUE: hold DAC_TRIG=1 and DAC_ADDR/DAC_DATA stable; on done_s=1 drive DAC_TRIG=0, set rr_ptr=DAC_ADDR+1 (mod 8), go RELEASE.
REQ-010 RELEASE: hold DAC_TRIG=0; on done_s=0 go IDLE.
REQ-011 SHALL keep a wait counter cleared on each state entry; if it reaches TIMEOUT_CYCLES in ISSUE or RELEASE, SHALL set ERR_TIMEOUT, re-set PENDING for DAC_ADDR, drive DAC_TRIG=0, go RELEASE (counter restarted) from ISSUE, or IDLE from RELEASE.
REQ-012 WR_EN to the channel in flight SHALL update shadow and set PENDING; the in-flight DAC_DATA SHALL stay unchanged.
REQ-013 Set on the same edge as clear (WR_EN, FORCE_ALL or timeout vs. IDLE capture) SHALL leave PENDING set.
REQ-014 ENABLE=0 SHALL block only new IDLE->ISSUE transitions; an in-flight transfer SHALL complete.
REQ-015 ERR_CLR SHALL clear ERR_TIMEOUT; a timeout on the same edge SHALL win.
REQ-016 BUSY SHALL be 1 exactly when state != IDLE.

Reset
REQ-017 OPB_RST_N=0 SHALL asynchronously force state IDLE; DAC_TRIG=0, DAC_ADDR=0, DAC_DATA=0, BUSY=0, PENDING=0, ERR_TIMEOUT=0; shadows 0; rr_ptr 0; wait counter 0; synchronizer flops 0.
REQ-018 Reset mid-transfer SHALL drop DAC_TRIG within the reset assertion and discard all pending updates.

Structure
REQ-019 State encoding, channel count (8), address width (3) and data width (8) SHALL live in a shared package dac_pkg.
REQ-020 The synchronizer SHALL be a separate sub-module sync_bit (parameter STAGES), reusable elsewhere.

Verification
REQ-021 Write ch3=0x5A -> DAC_TRIG rises after edge k+1 with ADDR=3, DATA=0x5A; model DONE after 20 cycles -> TRIG falls, PENDING=0.
REQ-022 Write ch1, ch5, ch6 in one burst -> transfers in order 1,5,6; then write ch0 and ch2 with rr_ptr=7 -> order 0,2.
REQ-023 During ch2 transfer, write ch2=0x11 -> current DATA unchanged; second transfer with 0x11 follows.
REQ-024 TIMEOUT_CYCLES=16, DONE held low -> ERR_TIMEOUT=1 after 16 ISSUE cycles, PENDING[ch] re-set; ERR_CLR clears it.
REQ-025 FORCE_ALL with ENABLE=0 -> PENDING=0xFF, no TRIG; ENABLE=1 -> eight transfers, channels 0..7.
REQ-026 OPB_RST_N low during ISSUE -> TRIG=0, PENDING=0 immediately; no transfer after release without new writes.
